// File: rtl/pcie_ltssm_multilane.sv
// Multi-lane PCIe LTSSM: timed Detect, Polling with per-lane TS counting, Configuration hold and L0.
// Optional compliance state is built in when LTSSM_COMPLIANCE_EN is defined.
module pcie_ltssm_multilane #(
    parameter int NUM_LANES       = 4,
    parameter int CLK_PER_MS      = 100000,
    parameter int DETECT_QUIET_MS = 12,
    parameter int POLL_ACTIVE_MS  = 24,
    parameter int POLL_CONFIG_MS  = 48,
    parameter int CONFIG_MS       = 24,
    parameter int TS1_TX_MIN      = 1024,
    parameter int TS_RX_REQ       = 8,
    parameter int TS2_TX_AFTER    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_LANES-1:0] lane_detect_i,
    input  logic [NUM_LANES-1:0] rx_elec_idle_exit_i,
    input  logic [NUM_LANES-1:0] rx_ts1_i,
    input  logic [NUM_LANES-1:0] rx_ts2_i,
    input  logic                 tx_os_done_i,
    input  logic                 cfg_done_i,
    input  logic                 link_down_req_i,
    input  logic                 link_disable_i,
    output logic [2:0]           state_o,
    output logic [1:0]           tx_os_type_o,
    output logic [NUM_LANES-1:0] lanes_active_o,
    output logic                 link_up_o,
    output logic                 en_8b10b_encoder_o,
    output logic                 en_128b130b_encoder_o
);

    localparam int PW    = $clog2(CLK_PER_MS);
    localparam int TXW   = $clog2(TS1_TX_MIN + 1);
    localparam int RXW   = $clog2(TS_RX_REQ + 1);
    localparam int POSTW = $clog2(TS2_TX_AFTER + 1);

    localparam logic [PW-1:0]    PS_LAST  = PW'(CLK_PER_MS - 1);
    localparam logic [TXW-1:0]   TX_MAX   = TXW'(TS1_TX_MIN);
    localparam logic [RXW-1:0]   RX_MAX   = RXW'(TS_RX_REQ);
    localparam logic [POSTW-1:0] POST_MAX = POSTW'(TS2_TX_AFTER);
    localparam logic [5:0]       DQ_MS    = 6'(DETECT_QUIET_MS);
    localparam logic [5:0]       PA_MS    = 6'(POLL_ACTIVE_MS);
    localparam logic [5:0]       PC_MS    = 6'(POLL_CONFIG_MS);
    localparam logic [5:0]       CF_MS    = 6'(CONFIG_MS);

    typedef enum logic [2:0] {
        DQUIET  = 3'd0,
        DACTIVE = 3'd1,
        PACTIVE = 3'd2,
        PCONFIG = 3'd3,
`ifdef LTSSM_COMPLIANCE_EN
        PCOMPL  = 3'd4,
`endif
        CONFIG  = 3'd5,
        L0      = 3'd6
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [PW-1:0]        prescale_r;
    logic [5:0]           ms_r;
    logic                 ms_tick_s;
    logic [TXW-1:0]       tx_cnt_r;
    logic [TXW-1:0]       tx_cnt_nxt_s;
    logic [RXW-1:0]       rx_cnt_r     [NUM_LANES];
    logic [RXW-1:0]       rx_cnt_nxt_s [NUM_LANES];
    logic [POSTW-1:0]     post_cnt_r;
    logic [POSTW-1:0]     post_cnt_nxt_s;
    logic                 ts2_seen_r;
    logic                 ts2_seen_nxt_s;
    logic [NUM_LANES-1:0] rx_pulse_s;
    logic [NUM_LANES-1:0] rx_full_s;
    logic                 all_full_s;
    logic                 tx_full_s;
    logic                 in_pactive_s;
    logic                 in_pconfig_s;
    logic [NUM_LANES-1:0] lanes_active_r;
    logic [NUM_LANES-1:0] next_mask_s;
    logic [1:0]           tx_type_nxt_s;
    logic [1:0]           tx_os_type_r;
    logic                 link_up_r;
    logic                 en_8b10b_r;

    // Counter next values; success and timeout decisions see this cycle's pulses.
    always_comb begin
        ms_tick_s    = (prescale_r == PS_LAST);
        in_pactive_s = (state_r == PACTIVE);
        in_pconfig_s = (state_r == PCONFIG);

        if (in_pactive_s) begin
            rx_pulse_s = (rx_ts1_i | rx_ts2_i) & lanes_active_r;
        end else if (in_pconfig_s) begin
            rx_pulse_s = rx_ts2_i & lanes_active_r;
        end else begin
            rx_pulse_s = {NUM_LANES{1'b0}};
        end

        for (int i = 0; i < NUM_LANES; i++) begin
            if (rx_pulse_s[i] && (rx_cnt_r[i] != RX_MAX)) begin
                rx_cnt_nxt_s[i] = rx_cnt_r[i] + RXW'(1'b1);
            end else begin
                rx_cnt_nxt_s[i] = rx_cnt_r[i];
            end
            rx_full_s[i] = (rx_cnt_nxt_s[i] == RX_MAX);
        end
        all_full_s = &(rx_full_s | ~lanes_active_r);

        if (in_pactive_s && tx_os_done_i && (tx_cnt_r != TX_MAX)) begin
            tx_cnt_nxt_s = tx_cnt_r + TXW'(1'b1);
        end else begin
            tx_cnt_nxt_s = tx_cnt_r;
        end
        tx_full_s = (tx_cnt_nxt_s == TX_MAX);

        ts2_seen_nxt_s = ts2_seen_r | (in_pconfig_s & (|(rx_ts2_i & lanes_active_r)));
        if (in_pconfig_s && ts2_seen_r && tx_os_done_i && (post_cnt_r != POST_MAX)) begin
            post_cnt_nxt_s = post_cnt_r + POSTW'(1'b1);
        end else begin
            post_cnt_nxt_s = post_cnt_r;
        end
    end

    // Next-state, lane-mask and output decode.
    always_comb begin
        next_state_s = state_r;
        next_mask_s  = lanes_active_r;
        if (link_disable_i) begin
            next_state_s = DQUIET;
        end else begin
            case (state_r)
                DQUIET: begin
                    if ((ms_r == DQ_MS) || (|rx_elec_idle_exit_i)) begin
                        next_state_s = DACTIVE;
                    end else begin
                        next_state_s = DQUIET;
                    end
                end
                DACTIVE: begin
                    if (ms_r == 6'd1) begin
                        if (lane_detect_i[0]) begin
                            next_state_s = PACTIVE;
                            next_mask_s  = lane_detect_i;
                        end else begin
                            next_state_s = DQUIET;
                        end
                    end else begin
                        next_state_s = DACTIVE;
                    end
                end
                PACTIVE: begin
                    if (tx_full_s && all_full_s) begin
                        next_state_s = PCONFIG;
                    end else if (ms_r == PA_MS) begin
                        if (tx_full_s && rx_full_s[0]) begin
                            next_state_s = PCONFIG;
                            next_mask_s  = lanes_active_r & rx_full_s;
                        end else begin
`ifdef LTSSM_COMPLIANCE_EN
                            next_state_s = PCOMPL;
`else
                            next_state_s = DQUIET;
`endif
                        end
                    end else begin
                        next_state_s = PACTIVE;
                    end
                end
                PCONFIG: begin
                    if (all_full_s && (post_cnt_nxt_s >= POST_MAX)) begin
                        next_state_s = CONFIG;
                    end else if (ms_r == PC_MS) begin
                        next_state_s = DQUIET;
                    end else begin
                        next_state_s = PCONFIG;
                    end
                end
`ifdef LTSSM_COMPLIANCE_EN
                PCOMPL: begin
                    if (|(rx_elec_idle_exit_i & lanes_active_r)) begin
                        next_state_s = PACTIVE;
                    end else begin
                        next_state_s = PCOMPL;
                    end
                end
`endif
                CONFIG: begin
                    if (cfg_done_i) begin
                        next_state_s = L0;
                    end else if (ms_r == CF_MS) begin
                        next_state_s = DQUIET;
                    end else begin
                        next_state_s = CONFIG;
                    end
                end
                L0: begin
                    if (link_down_req_i) begin
                        next_state_s = DQUIET;
                    end else begin
                        next_state_s = L0;
                    end
                end
                default: next_state_s = DQUIET;
            endcase
        end
        if (next_state_s == DQUIET) begin
            next_mask_s = {NUM_LANES{1'b0}};
        end else begin
            next_mask_s = next_mask_s;
        end

        case (next_state_s)
            PACTIVE: tx_type_nxt_s = 2'd1;
            PCONFIG: tx_type_nxt_s = 2'd2;
`ifdef LTSSM_COMPLIANCE_EN
            PCOMPL:  tx_type_nxt_s = 2'd3;
`endif
            CONFIG:  tx_type_nxt_s = 2'd1;
            default: tx_type_nxt_s = 2'd0;
        endcase
    end

    // State, timers, counters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r        <= DQUIET;
            lanes_active_r <= {NUM_LANES{1'b0}};
            prescale_r     <= {PW{1'b0}};
            ms_r           <= 6'd0;
            tx_cnt_r       <= {TXW{1'b0}};
            post_cnt_r     <= {POSTW{1'b0}};
            ts2_seen_r     <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                rx_cnt_r[i] <= {RXW{1'b0}};
            end
            tx_os_type_r   <= 2'd0;
            link_up_r      <= 1'b0;
            en_8b10b_r     <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            lanes_active_r <= next_mask_s;
            tx_os_type_r   <= tx_type_nxt_s;
            link_up_r      <= (next_state_s == L0);
            en_8b10b_r     <= (next_state_s >= PACTIVE) && (next_state_s <= L0);
            if (next_state_s != state_r) begin
                prescale_r <= {PW{1'b0}};
                ms_r       <= 6'd0;
                tx_cnt_r   <= {TXW{1'b0}};
                post_cnt_r <= {POSTW{1'b0}};
                ts2_seen_r <= 1'b0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    rx_cnt_r[i] <= {RXW{1'b0}};
                end
            end else if (!link_disable_i) begin
                if (ms_tick_s) begin
                    prescale_r <= {PW{1'b0}};
                    if (ms_r != 6'd63) begin
                        ms_r <= ms_r + 6'd1;
                    end
                end else begin
                    prescale_r <= prescale_r + PW'(1'b1);
                end
                tx_cnt_r   <= tx_cnt_nxt_s;
                post_cnt_r <= post_cnt_nxt_s;
                ts2_seen_r <= ts2_seen_nxt_s;
                for (int i = 0; i < NUM_LANES; i++) begin
                    rx_cnt_r[i] <= rx_cnt_nxt_s[i];
                end
            end
        end
    end

    assign state_o               = state_r;
    assign tx_os_type_o          = tx_os_type_r;
    assign lanes_active_o        = lanes_active_r;
    assign link_up_o             = link_up_r;
    assign en_8b10b_encoder_o    = en_8b10b_r;
    assign en_128b130b_encoder_o = 1'b0;

endmodule

// File: tb/tb_pcie_ltssm_multilane.sv
// Directed self-checking bench for pcie_ltssm_multilane (4 lanes, 10 clocks per ms, 16 TS1 minimum).
module tb_pcie_ltssm_multilane;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] lane_detect;
    logic [3:0] elec_idle_exit;
    logic [3:0] rx_ts1;
    logic [3:0] rx_ts2;
    logic       tx_os_done;
    logic       cfg_done;
    logic       link_down_req;
    logic       link_disable;
    logic [2:0] state;
    logic [1:0] tx_os_type;
    logic [3:0] lanes_active;
    logic       link_up;
    logic       en_8b10b;
    logic       en_128b130b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcie_ltssm_multilane #(
        .NUM_LANES(4),
        .CLK_PER_MS(10),
        .TS1_TX_MIN(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .lane_detect_i(lane_detect),
        .rx_elec_idle_exit_i(elec_idle_exit),
        .rx_ts1_i(rx_ts1),
        .rx_ts2_i(rx_ts2),
        .tx_os_done_i(tx_os_done),
        .cfg_done_i(cfg_done),
        .link_down_req_i(link_down_req),
        .link_disable_i(link_disable),
        .state_o(state),
        .tx_os_type_o(tx_os_type),
        .lanes_active_o(lanes_active),
        .link_up_o(link_up),
        .en_8b10b_encoder_o(en_8b10b),
        .en_128b130b_encoder_o(en_128b130b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int bound, output int n);
        n = 0;
        while ((state !== target) && (n < bound)) begin
            tick();
            n++;
        end
        checks++;
        if (state !== target) begin
            failures++;
            $display("FAIL wait_state: state=%0d after %0d cycles, expected %0d", state, n, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; lane_detect = 4'hF; elec_idle_exit = 4'h0; rx_ts1 = 4'h0; rx_ts2 = 4'h0;
        tx_os_done = 1'b0; cfg_done = 1'b0; link_down_req = 1'b0; link_disable = 1'b0;
        repeat (3) tick();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (tx_os_type !== 2'd0) begin failures++; $display("FAIL reset_tx: got %0d expected 0", tx_os_type); end
        checks++; if (lanes_active !== 4'h0) begin failures++; $display("FAIL reset_mask: got %h expected 0", lanes_active); end
        checks++; if (link_up !== 1'b0) begin failures++; $display("FAIL reset_link_up: got %b expected 0", link_up); end
        checks++; if (en_8b10b !== 1'b0) begin failures++; $display("FAIL reset_en8b10b: got %b expected 0", en_8b10b); end
        checks++; if (en_128b130b !== 1'b0) begin failures++; $display("FAIL reset_en128: got %b expected 0", en_128b130b); end
        rst = 1'b0;
    endtask

    task automatic test_detect();
        int n;
        wait_state(3'd1, 300, n);
        checks++; if (n != 121) begin failures++; $display("FAIL detect_quiet_time: got %0d cycles expected 121", n); end
        wait_state(3'd2, 50, n);
        checks++; if (n != 11) begin failures++; $display("FAIL detect_active_time: got %0d cycles expected 11", n); end
        checks++; if (lanes_active !== 4'hF) begin failures++; $display("FAIL detect_mask: got %h expected f", lanes_active); end
        checks++; if (tx_os_type !== 2'd1) begin failures++; $display("FAIL pactive_tx: got %0d expected 1", tx_os_type); end
        checks++; if (en_8b10b !== 1'b1) begin failures++; $display("FAIL pactive_en8b10b: got %b expected 1", en_8b10b); end
        checks++; if (link_up !== 1'b0) begin failures++; $display("FAIL pactive_link_up: got %b expected 0", link_up); end
    endtask

    task automatic test_bring_up();
        for (int i = 0; i < 16; i++) begin
            tx_os_done = 1'b1;
            rx_ts1 = (i < 8) ? 4'hF : 4'h0;
            tick();
            tx_os_done = 1'b0; rx_ts1 = 4'h0;
            if (i == 14) begin
                checks++; if (state !== 3'd2) begin failures++; $display("FAIL tx_not_full: state=%0d expected 2", state); end
            end
        end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL bringup_pconfig: state=%0d expected 3", state); end
        checks++; if (tx_os_type !== 2'd2) begin failures++; $display("FAIL pconfig_tx: got %0d expected 2", tx_os_type); end
        rx_ts2 = 4'hF; tx_os_done = 1'b1;
        tick();
        rx_ts2 = 4'h0; tx_os_done = 1'b0;
        for (int i = 1; i < 8; i++) begin
            rx_ts2 = 4'hF;
            tick();
            rx_ts2 = 4'h0;
        end
        for (int i = 0; i < 16; i++) begin
            tx_os_done = 1'b1;
            tick();
            tx_os_done = 1'b0;
            if (i == 14) begin
                checks++; if (state !== 3'd3) begin failures++; $display("FAIL post_same_cycle: state=%0d expected 3", state); end
            end
        end
        checks++; if (state !== 3'd5) begin failures++; $display("FAIL bringup_config: state=%0d expected 5", state); end
        checks++; if (tx_os_type !== 2'd1) begin failures++; $display("FAIL config_tx: got %0d expected 1", tx_os_type); end
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        checks++; if (state !== 3'd6) begin failures++; $display("FAIL bringup_l0: state=%0d expected 6", state); end
        checks++; if (link_up !== 1'b1) begin failures++; $display("FAIL l0_link_up: got %b expected 1", link_up); end
        checks++; if (en_8b10b !== 1'b1) begin failures++; $display("FAIL l0_en8b10b: got %b expected 1", en_8b10b); end
        checks++; if (tx_os_type !== 2'd0) begin failures++; $display("FAIL l0_tx: got %0d expected 0", tx_os_type); end
        checks++; if (lanes_active !== 4'hF) begin failures++; $display("FAIL l0_mask: got %h expected f", lanes_active); end
    endtask

    task automatic test_link_disable();
        int n;
        link_disable = 1'b1;
        tick();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL disable_state: state=%0d expected 0", state); end
        checks++; if (link_up !== 1'b0) begin failures++; $display("FAIL disable_link_up: got %b expected 0", link_up); end
        checks++; if (lanes_active !== 4'h0) begin failures++; $display("FAIL disable_mask: got %h expected 0", lanes_active); end
        checks++; if (en_8b10b !== 1'b0) begin failures++; $display("FAIL disable_en8b10b: got %b expected 0", en_8b10b); end
        repeat (200) tick();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL disable_hold: state=%0d expected 0", state); end
        link_disable = 1'b0;
        wait_state(3'd1, 300, n);
        checks++; if (n != 121) begin failures++; $display("FAIL disable_frozen_timer: got %0d cycles expected 121", n); end
        wait_state(3'd2, 50, n);
    endtask

    task automatic test_partial();
        int n;
        for (n = 1; n <= 241; n++) begin
            tx_os_done = (n <= 16);
            rx_ts1 = (n <= 8) ? 4'b0011 : 4'b0000;
            tick();
            tx_os_done = 1'b0; rx_ts1 = 4'h0;
            if (n == 240) begin
                checks++; if (state !== 3'd2) begin failures++; $display("FAIL partial_before_timeout: state=%0d expected 2", state); end
            end
        end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL partial_state: state=%0d expected 3", state); end
        checks++; if (lanes_active !== 4'b0011) begin failures++; $display("FAIL partial_mask: got %b expected 0011", lanes_active); end
        wait_state(3'd0, 600, n);
        checks++; if (n != 481) begin failures++; $display("FAIL pconfig_timeout: got %0d cycles expected 481", n); end
        checks++; if (lanes_active !== 4'h0) begin failures++; $display("FAIL pconfig_timeout_mask: got %h expected 0", lanes_active); end
    endtask

    task automatic test_lane0_missing();
        int n;
        lane_detect = 4'b1110;
        wait_state(3'd1, 300, n);
        wait_state(3'd0, 50, n);
        checks++; if (n != 11) begin failures++; $display("FAIL lane0_missing_time: got %0d cycles expected 11", n); end
        checks++; if (lanes_active !== 4'h0) begin failures++; $display("FAIL lane0_missing_mask: got %h expected 0", lanes_active); end
        lane_detect = 4'hF;
        elec_idle_exit = 4'b0100;
        tick();
        elec_idle_exit = 4'h0;
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL idle_exit_detect: state=%0d expected 1", state); end
        wait_state(3'd2, 50, n);
        for (n = 1; n <= 241; n++) begin
            tx_os_done = (n <= 16);
            rx_ts1 = (n <= 8) ? 4'b1110 : 4'b0000;
            tick();
            tx_os_done = 1'b0; rx_ts1 = 4'h0;
        end
`ifdef LTSSM_COMPLIANCE_EN
        checks++; if (state !== 3'd4) begin failures++; $display("FAIL lane0_silent_state: state=%0d expected 4", state); end
        checks++; if (tx_os_type !== 2'd3) begin failures++; $display("FAIL compliance_tx: got %0d expected 3", tx_os_type); end
        checks++; if (lanes_active !== 4'hF) begin failures++; $display("FAIL compliance_mask: got %h expected f", lanes_active); end
        elec_idle_exit = 4'b0001;
        tick();
        elec_idle_exit = 4'h0;
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL compliance_exit: state=%0d expected 2", state); end
`else
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL lane0_silent_state: state=%0d expected 0", state); end
        checks++; if (tx_os_type !== 2'd0) begin failures++; $display("FAIL lane0_silent_tx: got %0d expected 0", tx_os_type); end
        checks++; if (lanes_active !== 4'h0) begin failures++; $display("FAIL lane0_silent_mask: got %h expected 0", lanes_active); end
`endif
        wait_state(3'd2, 300, n);
    endtask

    task automatic test_simultaneous();
        int n;
        for (n = 1; n <= 241; n++) begin
            tx_os_done = (n <= 16);
            if (n <= 7)        rx_ts1 = 4'b1111;
            else if (n == 8)   rx_ts1 = 4'b1110;
            else if (n == 241) rx_ts1 = 4'b0001;
            else               rx_ts1 = 4'b0000;
            tick();
            tx_os_done = 1'b0; rx_ts1 = 4'h0;
            if (n == 240) begin
                checks++; if (state !== 3'd2) begin failures++; $display("FAIL simul_before: state=%0d expected 2", state); end
            end
        end
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL simul_success: state=%0d expected 3", state); end
        checks++; if (lanes_active !== 4'hF) begin failures++; $display("FAIL simul_mask: got %h expected f", lanes_active); end
    endtask

    task automatic test_reset_mid();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL async_reset_state: state=%0d expected 0", state); end
        checks++; if (tx_os_type !== 2'd0) begin failures++; $display("FAIL async_reset_tx: got %0d expected 0", tx_os_type); end
        checks++; if (lanes_active !== 4'h0) begin failures++; $display("FAIL async_reset_mask: got %h expected 0", lanes_active); end
        checks++; if (en_8b10b !== 1'b0) begin failures++; $display("FAIL async_reset_en8b10b: got %b expected 0", en_8b10b); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL post_reset_state: state=%0d expected 0", state); end
    endtask

    initial begin
        test_reset();
        test_detect();
        test_bring_up();
        test_link_disable();
        test_partial();
        test_lane0_missing();
        test_simultaneous();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
